// File: rtl/sdram_adapter_pkg.sv
// Shared types for the SDRAM request adapter: controller command encoding,
// adapter FSM states and the buffered request record.
package sdram_adapter_pkg;

    localparam int unsigned DefaultAddressWidth = 22;
    localparam int unsigned DefaultDataWidth    = 16;

    // Encoding expected on the controller's level-held command input.
    typedef enum logic [1:0] {
        CmdIdle  = 2'd0,
        CmdWrite = 2'd1,
        CmdRead  = 2'd2
    } sdram_command_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap
    } adapter_state_t;

    // Request record at the default widths. The top builds an equivalent
    // record at its own parameterised widths.
    typedef struct packed {
        logic                           write;
        logic [DefaultAddressWidth-1:0] address;
        logic [DefaultDataWidth-1:0]    data;
    } sdram_request_t;

    function automatic logic is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sdram_request_fifo.sv
// Synchronous request FIFO with head-of-queue lookahead. Depth must be a
// power of two so the pointers wrap without extra compare logic.
module sdram_request_fifo
    import sdram_adapter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter type         entry_t    = sdram_request_t
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  entry_t                      push_entry_i,
    input  logic                        pop_i,
    output entry_t                      head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    entry_t          mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_q == CntW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Overflow/underflow requests are dropped rather than corrupting pointers.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next-state pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy tracking guards every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/sdram_request_adapter.sv
// Client-side front end for the SDRAM controller: buffers valid/ready
// requests, drives the level-held command interface one request at a time
// with a mandatory idle cycle between commands, and returns a one-cycle
// response strobe per request in order.
// Optional: define SDRAM_ADAPTER_STATS_EN to add write_count/read_count.
module sdram_request_adapter
    import sdram_adapter_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 22,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_data,
    output logic                     rsp_valid,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     busy,
    output logic [1:0]               command,
    output logic [ADDRESS_WIDTH-1:0] data_address,
    output logic [DATA_WIDTH-1:0]    data_write,
    input  logic [DATA_WIDTH-1:0]    data_read,
    input  logic                     data_read_valid,
    input  logic                     data_write_done
`ifdef SDRAM_ADAPTER_STATS_EN
    ,
    output logic [31:0]              write_count,
    output logic [31:0]              read_count
`endif
);

    if (FIFO_DEPTH < 2 || !is_pow2(FIFO_DEPTH)) begin : g_bad_depth
        $fatal(1, "sdram_request_adapter: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic                     write;
        logic [ADDRESS_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0]    data;
    } req_entry_t;

    req_entry_t                  push_entry;
    req_entry_t                  fifo_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        issue_done;

    adapter_state_t              state_q;
    sdram_command_t              cmd_q;
    logic [ADDRESS_WIDTH-1:0]    addr_q;
    logic [DATA_WIDTH-1:0]       wdata_q;
    logic                        rsp_valid_q;
    logic                        rsp_write_q;
    logic [DATA_WIDTH-1:0]       rsp_data_q;

    assign push_entry = '{write: req_write, address: req_address, data: req_data};
    assign req_ready  = !fifo_full;
    assign fifo_push  = req_valid && req_ready;
    assign fifo_pop   = (state_q == StIdle) && !fifo_empty;

    // Only the strobe matching the in-flight command type completes it.
    assign issue_done = (state_q == StIssue)
                     && (((cmd_q == CmdWrite) && data_write_done)
                      || ((cmd_q == CmdRead) && data_read_valid));

    sdram_request_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (req_entry_t)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    // Issue FSM: pop -> hold command until its strobe -> one idle gap cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cmd_q       <= CmdIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fifo_pop) begin
                        cmd_q   <= fifo_head.write ? CmdWrite : CmdRead;
                        addr_q  <= fifo_head.address;
                        wdata_q <= fifo_head.data;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (issue_done) begin
                        cmd_q       <= CmdIdle;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= (cmd_q == CmdWrite);
                        rsp_data_q  <= (cmd_q == CmdWrite) ? '0 : data_read;
                        state_q     <= StGap;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    cmd_q   <= CmdIdle;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign command      = cmd_q;
    assign data_address = addr_q;
    assign data_write   = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_write    = rsp_write_q;
    assign rsp_data     = rsp_data_q;
    assign busy         = (fifo_count != '0) || (state_q != StIdle);

`ifdef SDRAM_ADAPTER_STATS_EN
    logic [31:0] write_count_q;
    logic [31:0] read_count_q;

    // Completion counters; they update on the same edge that raises rsp_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_count_q <= '0;
            read_count_q  <= '0;
        end else if (issue_done) begin
            if (cmd_q == CmdWrite) begin
                write_count_q <= write_count_q + 32'd1;
            end else begin
                read_count_q <= read_count_q + 32'd1;
            end
        end
    end

    assign write_count = write_count_q;
    assign read_count  = read_count_q;
`endif

endmodule
